// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// alu_sequencer : serial decode/exec/writeback sequencer for an external 8-bit ALU
// Rev 1.0
// ============================================================================
module alu_sequencer #(
   parameter int NREG = 4,
   parameter int DW   = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_valid_i,
   output logic          instr_ready_o,
   input  logic [15:0]   instr_i,
   output logic [DW-1:0] alu_a_o,
   output logic [DW-1:0] alu_b_o,
   output logic [2:0]    alu_sel_o,
   input  logic [DW-1:0] alu_out_i,
   input  logic          alu_carry_i,
   output logic          res_valid_o,
   input  logic          res_ready_i,
   output logic [DW-1:0] res_data_o,
   output logic          res_carry_o,
   output logic          res_zero_o,
   output logic          busy_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [15:0]     instr_q, instr_d;
   logic [DW-1:0]   regs_q [NREG];
   logic [DW-1:0]   regs_d [NREG];
   logic [DW-1:0]   alu_a_q, alu_a_d;
   logic [DW-1:0]   alu_b_q, alu_b_d;
   logic [2:0]      alu_sel_q, alu_sel_d;
   logic [DW-1:0]   result_q, result_d;
   logic            rcarry_q, rcarry_d;
   logic            carry_q, carry_d;
   logic            zero_q, zero_d;
   logic [DW-1:0]   res_data_q, res_data_d;

   logic            is_li;
   logic [2:0]      op;
   logic [1:0]      rd, rs1, rs2;
   logic [DW-1:0]   imm;

   assign is_li = instr_q[15];
   assign op    = instr_q[14:12];
   assign rd    = instr_q[11:10];
   assign rs1   = instr_q[9:8];
   assign rs2   = instr_q[7:6];
   assign imm   = instr_q[7:0];

   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      regs_d     = regs_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_sel_d  = alu_sel_q;
      result_d   = result_q;
      rcarry_d   = rcarry_q;
      carry_d    = carry_q;
      zero_d     = zero_q;
      res_data_d = res_data_q;
      case (state_q)
         S_IDLE: begin
            if (instr_valid_i) begin
               instr_d = instr_i;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (is_li) begin
               // LI keeps the carry flag, so route the current flag through the result path
               result_d = imm;
               rcarry_d = carry_q;
               state_d  = S_WB;
            end else begin
               alu_a_d   = regs_q[rs1];
               alu_b_d   = regs_q[rs2];
               alu_sel_d = op;
               state_d   = S_EXEC;
            end
         end
         S_EXEC: begin
            result_d = alu_out_i;
            rcarry_d = alu_carry_i;
            state_d  = S_WB;
         end
         S_WB: begin
            regs_d[rd] = result_q;
            carry_d    = rcarry_q;
            zero_d     = (result_q == '0);
            res_data_d = result_q;
            state_d    = S_RESP;
         end
         S_RESP: begin
            if (res_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         instr_q    <= '0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_sel_q  <= '0;
         result_q   <= '0;
         rcarry_q   <= 1'b0;
         carry_q    <= 1'b0;
         zero_q     <= 1'b0;
         res_data_q <= '0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         regs_q     <= regs_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_sel_q  <= alu_sel_d;
         result_q   <= result_d;
         rcarry_q   <= rcarry_d;
         carry_q    <= carry_d;
         zero_q     <= zero_d;
         res_data_q <= res_data_d;
      end
   end

   assign instr_ready_o = (state_q == S_IDLE);
   assign res_valid_o   = (state_q == S_RESP);
   assign busy_o        = (state_q != S_IDLE);
   assign alu_a_o       = alu_a_q;
   assign alu_b_o       = alu_b_q;
   assign alu_sel_o     = alu_sel_q;
   assign res_data_o    = res_data_q;
   assign res_carry_o   = carry_q;
   assign res_zero_o    = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_sequencer : directed + random instruction stream against an ISA-level model
// Rev 1.0
// ============================================================================
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [7:0]  alu_a, alu_b, alu_out;
   logic [2:0]  alu_sel;
   logic        alu_carry;
   logic        res_valid, res_ready;
   logic [7:0]  res_data;
   logic        res_carry, res_zero, busy;

   int vectors    = 0;
   int miscompares = 0;

   logic [7:0] m_reg [4];
   logic       m_carry, m_zero;

   always #5 clk = ~clk;

   alu_sequencer #(.NREG(4), .DW(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr_valid_i(instr_valid),
      .instr_ready_o(instr_ready),
      .instr_i      (instr),
      .alu_a_o      (alu_a),
      .alu_b_o      (alu_b),
      .alu_sel_o    (alu_sel),
      .alu_out_i    (alu_out),
      .alu_carry_i  (alu_carry),
      .res_valid_o  (res_valid),
      .res_ready_i  (res_ready),
      .res_data_o   (res_data),
      .res_carry_o  (res_carry),
      .res_zero_o   (res_zero),
      .busy_o       (busy)
   );

   // External ALU: {carry, result}
   function automatic logic [8:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
      int r;
      case (s)
         3'd0: begin r = int'(a) + int'(b); return {r > 255, 8'(r)}; end
         3'd1: return {a < b, 8'(a - b)};
         3'd2: return {1'b0, a & b};
         3'd3: return {1'b0, a | b};
         3'd4: return {1'b0, a ^ b};
         3'd5: begin r = int'(a) * int'(b); return {r > 255, 8'(r)}; end
         3'd6: begin
            if (b == 8'd0) return {1'b1, 8'd0};
            return {1'b0, a / b};
         end
         default: return {1'b0, (a == b) ? 8'd1 : 8'd0};
      endcase
   endfunction

   always_comb {alu_carry, alu_out} = alu_f(alu_sel, alu_a, alu_b);

   function automatic logic [15:0] li(input logic [1:0] rd, input logic [7:0] imm);
      return {1'b1, 3'b000, rd, 2'b00, imm};
   endfunction

   function automatic logic [15:0] aop(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2);
      return {1'b0, op, rd, rs1, rs2, 6'b0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_reg[i] = 8'd0;
      m_carry = 1'b0;
      m_zero  = 1'b0;
   endtask

   // Architectural effect of one instruction
   task automatic model_exec(input logic [15:0] w, output logic [7:0] d, output logic c, output logic z);
      if (w[15]) begin
         d = w[7:0];
         c = m_carry;
      end else begin
         {c, d} = alu_f(w[14:12], m_reg[w[9:8]], m_reg[w[7:6]]);
      end
      z = (d == 8'd0);
      m_reg[w[11:10]] = d;
      m_carry = c;
      m_zero  = z;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_res_valid"}, {31'b0, res_valid}, 32'd0);
      chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
      chk({tag, "_instr_ready"}, {31'b0, instr_ready}, 32'd1);
      chk({tag, "_alu_a"}, {24'b0, alu_a}, 32'd0);
      chk({tag, "_alu_b"}, {24'b0, alu_b}, 32'd0);
      chk({tag, "_alu_sel"}, {29'b0, alu_sel}, 32'd0);
      chk({tag, "_res_data"}, {24'b0, res_data}, 32'd0);
      chk({tag, "_res_carry"}, {31'b0, res_carry}, 32'd0);
      chk({tag, "_res_zero"}, {31'b0, res_zero}, 32'd0);
   endtask

   // Issue one instruction, check its timing and result, optionally stall the response.
   task automatic run(input logic [15:0] w, input int hold, input logic [15:0] offered);
      logic [7:0] ed, ea, eb;
      logic       ec, ez;
      bit         got;
      int         lat;
      @(negedge clk);
      instr       = w;
      instr_valid = 1'b1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (instr_ready) got = 1;
         else @(negedge clk);
      end
      chk("accept", {31'b0, got}, 32'd1);
      ea = m_reg[w[9:8]];
      eb = m_reg[w[7:6]];
      model_exec(w, ed, ec, ez);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instr       = 16'($urandom);
      lat = 0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (!w[15] && lat == 2) begin
            chk("exec_alu_a", {24'b0, alu_a}, {24'b0, ea});
            chk("exec_alu_b", {24'b0, alu_b}, {24'b0, eb});
            chk("exec_alu_sel", {29'b0, alu_sel}, {29'b0, w[14:12]});
            chk("exec_busy", {31'b0, busy}, 32'd1);
         end
         if (res_valid) got = 1;
      end
      chk("latency", lat, w[15] ? 32'd3 : 32'd4);
      chk("res_data", {24'b0, res_data}, {24'b0, ed});
      chk("res_carry", {31'b0, res_carry}, {31'b0, ec});
      chk("res_zero", {31'b0, res_zero}, {31'b0, ez});
      chk("resp_instr_ready", {31'b0, instr_ready}, 32'd0);
      for (int h = 0; h < hold; h++) begin
         instr       = offered;
         instr_valid = 1'b1;
         @(negedge clk);
         chk("hold_res_valid", {31'b0, res_valid}, 32'd1);
         chk("hold_res_data", {24'b0, res_data}, {24'b0, ed});
         chk("hold_res_flags", {30'b0, res_carry, res_zero}, {30'b0, ec, ez});
         chk("hold_instr_ready", {31'b0, instr_ready}, 32'd0);
      end
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      @(negedge clk);
      instr_valid = 1'b0;
      chk("post_res_valid", {31'b0, res_valid}, 32'd0);
      chk("post_instr_ready", {31'b0, instr_ready}, 32'd1);
      chk("post_busy", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w;
      rst_n = 1'b0; instr_valid = 1'b0; res_ready = 1'b0; instr = 16'h0;
      model_reset();
      repeat (2) @(negedge clk);
      chk_reset_outputs("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset_outputs("after_reset");

      run(li(2'd0, 8'd200), 0, 16'h0);
      run(li(2'd1, 8'd100), 0, 16'h0);
      run(aop(3'd0, 2'd2, 2'd0, 2'd1), 0, 16'h0);
      chk("plan_add", {22'b0, res_data, res_carry, res_zero}, {22'b0, 8'd44, 1'b1, 1'b0});

      run(li(2'd0, 8'd5), 0, 16'h0);
      run(li(2'd1, 8'd7), 0, 16'h0);
      run(aop(3'd1, 2'd3, 2'd0, 2'd1), 0, 16'h0);
      chk("plan_sub1", {23'b0, res_data, res_carry}, {23'b0, 8'd254, 1'b1});
      run(aop(3'd1, 2'd3, 2'd1, 2'd0), 0, 16'h0);
      chk("plan_sub2", {23'b0, res_data, res_carry}, {23'b0, 8'd2, 1'b0});

      run(li(2'd0, 8'd16), 0, 16'h0);
      run(aop(3'd5, 2'd1, 2'd0, 2'd0), 0, 16'h0);
      chk("plan_mul", {22'b0, res_data, res_carry, res_zero}, {22'b0, 8'd0, 1'b1, 1'b1});
      run(li(2'd2, 8'd0), 0, 16'h0);
      run(aop(3'd6, 2'd3, 2'd0, 2'd2), 0, 16'h0);
      chk("plan_div0", {23'b0, res_data, res_carry}, {23'b0, 8'd0, 1'b1});

      run(li(2'd0, 8'h5A), 0, 16'h0);
      run(aop(3'd7, 2'd1, 2'd0, 2'd0), 0, 16'h0);
      chk("plan_cmp", {24'b0, res_data}, 32'd1);
      run(aop(3'd4, 2'd2, 2'd0, 2'd0), 0, 16'h0);
      chk("plan_xor", {23'b0, res_data, res_zero}, {23'b0, 8'd0, 1'b1});
      run(li(2'd3, 8'hFF), 0, 16'h0);
      chk("plan_li_flags", {30'b0, res_carry, res_zero}, {30'b0, 1'b0, 1'b0});

      // Stall the response with another instruction waiting, then issue it
      w = li(2'd3, 8'h77);
      run(aop(3'd0, 2'd1, 2'd0, 2'd3), 6, w);
      run(w, 0, 16'h0);

      // Reset during EXEC aborts the ADD without writeback
      run(li(2'd0, 8'd1), 0, 16'h0);
      run(li(2'd1, 8'd2), 0, 16'h0);
      @(negedge clk);
      instr = aop(3'd0, 2'd2, 2'd0, 2'd1);
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_in_exec_sel", {29'b0, alu_sel}, 32'd0);
      chk("abort_in_exec_busy", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("abort_async");
      @(negedge clk);
      chk_reset_outputs("abort_held");
      rst_n = 1'b1;
      model_reset();
      run(aop(3'd0, 2'd3, 2'd2, 2'd2), 0, 16'h0);
      chk("abort_r2_zero", {23'b0, res_data, res_zero}, {23'b0, 8'd0, 1'b1});

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 2) == 0)
            w = li(2'($urandom), 8'($urandom));
         else
            w = aop(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
         run(w, $urandom_range(0, 2), 16'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
